// File: rtl/bert_fetch_pkg.sv
// Shared types for the BERT buffer fetch engine.
// Holds the FSM state encoding, the per-job configuration snapshot and the
// skid FIFO depth rule used by both the top level and its credit counter.
package bert_fetch_pkg;

  // Default widths; the top-level parameters take these as their defaults so
  // the configuration snapshot struct lines up with the port widths.
  localparam int FETCH_ADDR_W = 16;
  localparam int FETCH_CNT_W  = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fetch_state_e;

  // Job configuration captured on an accepted start. Counts are held as
  // "last index" values so the walk compares directly against them.
  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] stride;
    logic [FETCH_CNT_W-1:0]  word_last;
    logic [FETCH_CNT_W-1:0]  tile_last;
    logic                    dbuf_en;
  } fetch_cfg_t;

  // Room for every read in the BRAM pipeline plus two words of slack, which
  // keeps one word per clock flowing while the consumer accepts every cycle.
  function automatic int fifo_depth(input int rd_lat);
    return rd_lat + 2;
  endfunction

  // A programmed count of 0 behaves as 1, so its last index is 0 either way.
  function automatic logic [FETCH_CNT_W-1:0] count_last(input logic [FETCH_CNT_W-1:0] cnt);
    return (cnt == '0) ? '0 : cnt - FETCH_CNT_W'(1);
  endfunction

endpackage

// File: rtl/fetch_skid_fifo.sv
// Small synchronous FIFO with first-word fall-through read side.
// Latency: a word written at a clock edge is visible on rd_dat the next cycle.
// Backpressure: writes are ignored when full (callers gate on count); flush empties in one clock.
// Ports: clk/rst_n; flush clears contents; wr_vld/wr_dat push; rd_vld/rd_rdy/rd_dat pop;
//        count is the current occupancy.
module fetch_skid_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       wr_vld,
  input  logic [WIDTH-1:0]           wr_dat,
  input  logic                       rd_rdy,
  output logic                       rd_vld,
  output logic [WIDTH-1:0]           rd_dat,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign rd_vld = (count_q != '0);
  assign rd_dat = mem_q[rd_ptr_q];
  assign count  = count_q;
  assign push   = wr_vld && (count_q != CNT_W'(DEPTH));
  assign pop    = rd_rdy && rd_vld;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (push && !flush) mem_d[wr_ptr_q] = wr_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is presented until count says so.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/tiled_bram_fetch_engine.sv
// Tiled strided BRAM read engine feeding a valid/ready stream with tile/job markers.
// Latency: first bram_en one clock after start; first m_valid RD_LAT+2 clocks after start.
// Backpressure: reads issue only against free FIFO credits, so no word is ever dropped.
// Ports: start/abort control; cfg_* job setup (sampled on accepted start); bram_en/bram_addr/
//        bram_dout read port B; m_valid/m_ready/m_data/m_tile_last/m_last stream out;
//        bank, busy, done status.
module tiled_bram_fetch_engine
  import bert_fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = FETCH_ADDR_W,
  parameter int                    DATA_WIDTH  = 256,
  parameter int                    RD_LAT      = 2,
  parameter int                    CNT_WIDTH   = FETCH_CNT_W,
  parameter logic [ADDR_WIDTH-1:0] BANK_OFFSET = 'h8000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  input  logic [CNT_WIDTH-1:0]  cfg_tile_words,
  input  logic [CNT_WIDTH-1:0]  cfg_num_tiles,
  input  logic [ADDR_WIDTH-1:0] cfg_stride,
  input  logic                  cfg_dbuf_en,
  output logic                  bram_en,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  input  logic [DATA_WIDTH-1:0] bram_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_tile_last,
  output logic                  m_last,
  output logic                  bank,
  output logic                  busy,
  output logic                  done
);

  localparam int FIFO_DEPTH = fifo_depth(RD_LAT);
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int CRED_W     = $clog2(2 * FIFO_DEPTH + 1);

  fetch_state_e            state_q, state_d;
  fetch_cfg_t              cfg_q, cfg_d;
  logic                    bank_q, bank_d;
  logic [CNT_WIDTH-1:0]    word_q, word_d;
  logic [CNT_WIDTH-1:0]    tile_q, tile_d;
  logic [ADDR_WIDTH-1:0]   tile_base_q, tile_base_d;
  logic [RD_LAT-1:0]       vld_sr_q, vld_sr_d;
  logic [RD_LAT-1:0]       tl_sr_q, tl_sr_d;
  logic [RD_LAT-1:0]       last_sr_q, last_sr_d;

  logic                    start_acc, abort_job, credit_ok, m_hs;
  logic                    issue_word_last, issue_last;
  logic [CRED_W-1:0]       in_flight;
  logic [FIFO_CNT_W-1:0]   fifo_count;
  logic                    fifo_rd_vld;
  logic [DATA_WIDTH+1:0]   fifo_rd_dat;
  logic [ADDR_WIDTH-1:0]   addr_cur;

  assign start_acc       = (state_q == ST_IDLE) && start && !abort;
  assign abort_job       = abort && ((state_q == ST_ISSUE) || (state_q == ST_DRAIN));
  assign issue_word_last = (word_q == cfg_q.word_last);
  assign issue_last      = issue_word_last && (tile_q == cfg_q.tile_last);
  assign addr_cur        = tile_base_q + ADDR_WIDTH'(word_q) + (bank_q ? BANK_OFFSET : '0);

  // Reads still inside the BRAM pipeline, including the one landing in the FIFO this clock.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LAT; i++) in_flight = in_flight + CRED_W'(vld_sr_q[i]);
  end

  assign credit_ok = (in_flight + CRED_W'(fifo_count)) < CRED_W'(FIFO_DEPTH);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_acc) state_d = ST_ISSUE;
      ST_ISSUE: begin
        if (abort)                      state_d = ST_IDLE;
        else if (bram_en && issue_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (abort)               state_d = ST_IDLE;
        else if (m_hs && m_last) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    bram_en = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_ISSUE: begin
        bram_en = credit_ok;
        busy    = 1'b1;
      end
      ST_DRAIN: busy = 1'b1;
      ST_DONE:  done = 1'b1;
      default:  ;
    endcase
  end

  // Address walk: word-major inside a tile, tile base advanced by stride.
  always_comb begin
    cfg_d       = cfg_q;
    bank_d      = bank_q;
    word_d      = word_q;
    tile_d      = tile_q;
    tile_base_d = tile_base_q;
    if (start_acc) begin
      cfg_d.stride    = cfg_stride;
      cfg_d.word_last = count_last(cfg_tile_words);
      cfg_d.tile_last = count_last(cfg_num_tiles);
      cfg_d.dbuf_en   = cfg_dbuf_en;
      word_d          = '0;
      tile_d          = '0;
      tile_base_d     = cfg_base;
    end else if (bram_en) begin
      if (issue_word_last) begin
        word_d      = '0;
        tile_d      = tile_q + CNT_WIDTH'(1);
        tile_base_d = tile_base_q + cfg_q.stride;
      end else begin
        word_d = word_q + CNT_WIDTH'(1);
      end
    end
    if ((state_q == ST_DONE) && cfg_q.dbuf_en) bank_d = ~bank_q;
  end

  // Markers ride alongside each read so they meet their data at the FIFO input.
  always_comb begin
    vld_sr_d  = '0;
    tl_sr_d   = '0;
    last_sr_d = '0;
    if (!abort_job) begin
      vld_sr_d[0]  = bram_en;
      tl_sr_d[0]   = issue_word_last;
      last_sr_d[0] = issue_last;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_sr_d[i]  = vld_sr_q[i-1];
        tl_sr_d[i]   = tl_sr_q[i-1];
        last_sr_d[i] = last_sr_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cfg_q       <= '0;
      bank_q      <= 1'b0;
      word_q      <= '0;
      tile_q      <= '0;
      tile_base_q <= '0;
      vld_sr_q    <= '0;
      tl_sr_q     <= '0;
      last_sr_q   <= '0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      bank_q      <= bank_d;
      word_q      <= word_d;
      tile_q      <= tile_d;
      tile_base_q <= tile_base_d;
      vld_sr_q    <= vld_sr_d;
      tl_sr_q     <= tl_sr_d;
      last_sr_q   <= last_sr_d;
    end
  end

  fetch_skid_fifo #(
    .WIDTH (DATA_WIDTH + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (abort_job),
    .wr_vld (vld_sr_q[RD_LAT-1]),
    .wr_dat ({tl_sr_q[RD_LAT-1], last_sr_q[RD_LAT-1], bram_dout}),
    .rd_rdy (m_ready),
    .rd_vld (fifo_rd_vld),
    .rd_dat (fifo_rd_dat),
    .count  (fifo_count)
  );

  // Payload is masked when idle so stale FIFO contents never leak out.
  assign m_valid     = fifo_rd_vld;
  assign m_hs        = m_valid && m_ready;
  assign m_data      = fifo_rd_vld ? fifo_rd_dat[DATA_WIDTH-1:0] : '0;
  assign m_tile_last = fifo_rd_vld && fifo_rd_dat[DATA_WIDTH+1];
  assign m_last      = fifo_rd_vld && fifo_rd_dat[DATA_WIDTH];
  assign bram_addr   = bram_en ? addr_cur : '0;
  assign bank        = bank_q;

endmodule

// File: tb/tb_tiled_bram_fetch_engine.sv
module tb_tiled_bram_fetch_engine;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [15:0]  cfg_base = '0;
  logic [11:0]  cfg_tile_words = '0;
  logic [11:0]  cfg_num_tiles = '0;
  logic [15:0]  cfg_stride = '0;
  logic         cfg_dbuf_en = 1'b0;
  logic         bram_en;
  logic [15:0]  bram_addr;
  logic [255:0] bram_dout;
  logic         m_valid;
  logic         m_ready = 1'b1;
  logic [255:0] m_data;
  logic         m_tile_last, m_last, bank, busy, done;

  int n_vec = 0;
  int n_err = 0;

  tiled_bram_fetch_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_base(cfg_base), .cfg_tile_words(cfg_tile_words), .cfg_num_tiles(cfg_num_tiles),
    .cfg_stride(cfg_stride), .cfg_dbuf_en(cfg_dbuf_en),
    .bram_en(bram_en), .bram_addr(bram_addr), .bram_dout(bram_dout),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_tile_last(m_tile_last), .m_last(m_last),
    .bank(bank), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Memory contents are a function of the address, so every word identifies its source.
  function automatic logic [255:0] dword(input logic [15:0] a);
    return {8{a, ~a}};
  endfunction

  // BRAM port B model with two clocks of read latency.
  logic [255:0] rd_s1, rd_s2;
  always @(posedge clk) begin
    if (bram_en) rd_s1 <= dword(bram_addr);
    rd_s2 <= rd_s1;
  end
  assign bram_dout = rd_s2;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Ready pattern: held high, or toggling 1,0,1,0 each clock.
  logic rdy_mode = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_ready = rdy_mode ? ~m_ready : 1'b1;
    end
  end

  // Monitor
  int           cyc = 0;
  int           start_cyc = 0;
  int           first_en = -1;
  int           first_mv = -1;
  int           done_cnt = 0;
  int           stall_err = 0;
  int           fifo_max = 0;
  logic         stall_pend = 1'b0;
  logic [257:0] stall_hold = '0;
  logic [15:0]  iss_q[$];
  logic [255:0] rcv_dat[$];
  logic         rcv_tl[$];
  logic         rcv_last[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (start && !abort) start_cyc = cyc;
      if (bram_en) begin
        iss_q.push_back(bram_addr);
        if (first_en < 0) first_en = cyc - start_cyc;
      end
      if (m_valid && first_mv < 0) first_mv = cyc - start_cyc;
      if (m_valid && m_ready) begin
        rcv_dat.push_back(m_data);
        rcv_tl.push_back(m_tile_last);
        rcv_last.push_back(m_last);
      end
      if (done) done_cnt++;
      if (stall_pend && (!m_valid || {m_tile_last, m_last, m_data} != stall_hold)) stall_err++;
      stall_pend = m_valid && !m_ready;
      stall_hold = {m_tile_last, m_last, m_data};
      if (int'(dut.fifo_count) > fifo_max) fifo_max = int'(dut.fifo_count);
    end
  end

  task automatic clear_obs();
    iss_q.delete();
    rcv_dat.delete();
    rcv_tl.delete();
    rcv_last.delete();
    done_cnt   = 0;
    stall_err  = 0;
    stall_pend = 1'b0;
    fifo_max   = 0;
    first_en   = -1;
    first_mv   = -1;
  endtask

  task automatic start_job(input logic [15:0] base, input logic [11:0] tw, input logic [11:0] nt,
                           input logic [15:0] stride, input logic dbuf, input logic exp_bank);
    @(posedge clk);
    #1;
    clear_obs();
    cfg_base = base; cfg_tile_words = tw; cfg_num_tiles = nt;
    cfg_stride = stride; cfg_dbuf_en = dbuf; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    // Disturb the configuration: the running job must keep its sampled copy.
    cfg_base = ~base; cfg_tile_words = tw + 12'd1; cfg_num_tiles = nt + 12'd1;
    cfg_stride = stride + 16'h0011; cfg_dbuf_en = ~dbuf;
    chk("busy_on_start", busy, 1'b1);
    chk("bank_in_job", bank, exp_bank);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_cnt != 0) break;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_job(input logic [15:0] base, input logic [11:0] tw, input logic [11:0] nt,
                           input logic [15:0] stride, input logic [15:0] off, input logic bank_after);
    int twn, ntn, n, idx;
    logic [15:0]  ea;
    logic [255:0] d, e;
    twn = (tw == 0) ? 1 : int'(tw);
    ntn = (nt == 0) ? 1 : int'(nt);
    n   = twn * ntn;
    chk("issue_count", iss_q.size(), n);
    chk("word_count", rcv_dat.size(), n);
    idx = 0;
    for (int t = 0; t < ntn; t++) begin
      for (int w = 0; w < twn; w++) begin
        ea = 16'(int'(base) + t * int'(stride) + w + int'(off));
        if (idx < iss_q.size()) chk("issue_addr", iss_q[idx], ea);
        if (idx < rcv_dat.size()) begin
          d = rcv_dat[idx];
          e = dword(ea);
          chk("stream_word", {rcv_tl[idx], rcv_last[idx], d[63:0]},
              {logic'(w == twn - 1), logic'(idx == n - 1), e[63:0]});
        end
        idx++;
      end
    end
    chk("done_pulses", done_cnt, 1);
    chk("first_en_latency", first_en, 1);
    chk("first_valid_not_early", first_mv >= 3, 1'b1);
    chk("busy_after_done", busy, 1'b0);
    chk("bank_after_done", bank, bank_after);
  endtask

  task automatic check_outs_zero(input string tag);
    chk(tag, {bram_en, bram_addr, m_valid, |m_data, m_tile_last, m_last, bank, busy, done}, '0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n_at;
    logic fell;

    // Reset
    #12;
    check_outs_zero("reset_outputs");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_outs_zero("idle_after_reset");

    // Basic 3x4 job, ready held high
    start_job(16'h0100, 12'd4, 12'd3, 16'h0040, 1'b0, 1'b0);
    wait_done(300);
    check_job(16'h0100, 12'd4, 12'd3, 16'h0040, 16'h0000, 1'b0);

    // Same job with ready toggling
    rdy_mode = 1'b1;
    start_job(16'h0100, 12'd4, 12'd3, 16'h0040, 1'b0, 1'b0);
    wait_done(300);
    rdy_mode = 1'b0;
    check_job(16'h0100, 12'd4, 12'd3, 16'h0040, 16'h0000, 1'b0);
    chk("stall_stable", stall_err, 0);
    chk("fifo_peak_le_depth", fifo_max <= 4, 1'b1);

    // Double-buffered: two jobs, second lands in bank 1
    start_job(16'h0100, 12'd4, 12'd3, 16'h0040, 1'b1, 1'b0);
    wait_done(300);
    check_job(16'h0100, 12'd4, 12'd3, 16'h0040, 16'h0000, 1'b1);
    start_job(16'h0100, 12'd4, 12'd3, 16'h0040, 1'b1, 1'b1);
    wait_done(300);
    check_job(16'h0100, 12'd4, 12'd3, 16'h0040, 16'h8000, 1'b0);

    // Address wrap
    start_job(16'hFFFE, 12'd4, 12'd1, 16'h0000, 1'b0, 1'b0);
    wait_done(300);
    check_job(16'hFFFE, 12'd4, 12'd1, 16'h0000, 16'h0000, 1'b0);

    // Abort after 5 words, with a concurrent start that must be ignored
    start_job(16'h0100, 12'd4, 12'd3, 16'h0040, 1'b1, 1'b0);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (rcv_dat.size() >= 5) break;
    end
    chk("abort_point_reached", rcv_dat.size() >= 5, 1'b1);
    #1;
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    start = 1'b0;
    chk("abort_en_drop", bram_en, 1'b0);
    n_at = iss_q.size();
    fell = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (!busy) begin
        fell = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("abort_busy_fall", fell, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt, 0);
    chk("abort_no_more_issue", iss_q.size(), n_at);
    chk("abort_stream_idle", {m_valid, busy}, 2'b00);
    chk("abort_bank_kept", bank, 1'b0);

    // Full job after abort
    start_job(16'h0100, 12'd4, 12'd3, 16'h0040, 1'b0, 1'b0);
    wait_done(300);
    check_job(16'h0100, 12'd4, 12'd3, 16'h0040, 16'h0000, 1'b0);

    // Abort and start together while idle
    @(posedge clk);
    #1;
    clear_obs();
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    chk("abort_start_idle_busy", busy, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("abort_start_idle_issue", iss_q.size(), 0);

    // Zero counts behave as one word, one tile
    start_job(16'h0234, 12'd0, 12'd0, 16'h0040, 1'b1, 1'b0);
    wait_done(300);
    check_job(16'h0234, 12'd0, 12'd0, 16'h0040, 16'h0000, 1'b1);

    // Reset in the middle of a bank-1 job
    start_job(16'h0100, 12'd4, 12'd3, 16'h0040, 1'b0, 1'b1);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (rcv_dat.size() >= 2) break;
    end
    chk("reset_point_reached", rcv_dat.size() >= 2, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check_outs_zero("reset_mid_job");
    n_at = iss_q.size();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check_outs_zero("idle_after_mid_reset");
    chk("no_issue_after_mid_reset", iss_q.size(), n_at);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
